// File: rtl/ecc_fault_detc_pipe.sv
// Lockstep SECDED checker for FIFO read data: dual decoders, compare, counters,
// one-shot error injection and a mismatch-persistence FSM with a sticky fatal flag.

module ecc_secded_dec #(
  parameter int unsigned DATA_WIDTH   = 131,
  parameter int unsigned PARITY_WIDTH = 9
) (
  input  logic                    bypass,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [PARITY_WIDTH-1:0] parity,
  output logic                    sbit_c,
  output logic                    dbit_c,
  output logic [DATA_WIDTH-1:0]   mask_c
);
  localparam int unsigned CHK_W = PARITY_WIDTH - 1;
  localparam int unsigned TOTAL = DATA_WIDTH + CHK_W;

  // Hamming position of data bit j: data fills the non-power-of-two positions in order
  function automatic logic [CHK_W-1:0] data_pos(input int unsigned j);
    int unsigned p;
    int unsigned k;
    p = 0;
    k = 0;
    for (int unsigned q = 1; q <= TOTAL; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (k == j) p = q;
        k++;
      end
    end
    return CHK_W'(p);
  endfunction

  logic [CHK_W-1:0] syn_c;
  logic             odd_c;

  always_comb begin
    syn_c = parity[CHK_W-1:0];
    odd_c = ^{data, parity};
    for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
      if (data[j]) syn_c = syn_c ^ data_pos(j);
    end
    sbit_c = ~bypass & odd_c;
    dbit_c = ~bypass & ~odd_c & (syn_c != '0);
    mask_c = '0;
    for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
      mask_c[j] = sbit_c & (syn_c == data_pos(j));
    end
  end
endmodule

module ecc_fault_detc_pipe #(
  parameter int unsigned DATA_WIDTH   = 131,
  parameter int unsigned PARITY_WIDTH = 9,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ecc_fault_detc_en,
  input  logic                    bypass,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic                    ecc_fault,
  output logic                    fault_fatal,
  input  logic                    fatal_clr,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  input  logic                    inj_arm,
  input  logic [1:0]              inj_mode
);
  localparam int unsigned RUN_W = $clog2(FAULT_THRESH + 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic                    arm_q;
  logic [1:0]              mode_q;
  logic [DATA_WIDTH-1:0]   inj0_c, inj1_c, dec_data0_c, dec_data1_c;
  logic [DATA_WIDTH-1:0]   mask0_c, mask1_c;
  logic                    sbit0_c, dbit0_c, sbit1_c, dbit1_c;
  logic                    accept_c, fault_c;

  assign in_rdy   = ~out_vld | out_rdy;
  assign accept_c = in_vld & in_rdy;

  // Injection flips are applied only while armed; mode 1 corrupts decoder 1 alone
  always_comb begin
    inj0_c = '0;
    inj1_c = '0;
    if (arm_q) begin
      case (mode_q)
        2'd1: inj1_c[0] = 1'b1;
        2'd2: begin inj0_c[0] = 1'b1; inj1_c[0] = 1'b1; end
        2'd3: begin inj0_c[1:0] = 2'b11; inj1_c[1:0] = 2'b11; end
        default: ;
      endcase
    end
  end

  assign dec_data0_c = data_in ^ inj0_c;
  assign dec_data1_c = data_in ^ inj1_c;

  ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec0 (
    .bypass(bypass), .data(dec_data0_c), .parity(parity_in),
    .sbit_c(sbit0_c), .dbit_c(dbit0_c), .mask_c(mask0_c)
  );

  ecc_secded_dec #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec1 (
    .bypass(bypass), .data(dec_data1_c), .parity(parity_in),
    .sbit_c(sbit1_c), .dbit_c(dbit1_c), .mask_c(mask1_c)
  );

  assign fault_c = ecc_fault_detc_en & ({sbit0_c, dbit0_c, mask0_c} != {sbit1_c, dbit1_c, mask1_c});

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Output stage, injection arm and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      data_out  <= '0;
      sbit_err  <= 1'b0;
      dbit_err  <= 1'b0;
      ecc_fault <= 1'b0;
      arm_q     <= 1'b0;
      mode_q    <= 2'd0;
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
    end else begin
      if (accept_c) begin
        out_vld   <= 1'b1;
        data_out  <= fault_c ? dec_data0_c : (dec_data0_c ^ mask0_c);
        sbit_err  <= sbit0_c;
        dbit_err  <= dbit0_c;
        ecc_fault <= fault_c;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
      if (inj_arm) begin
        arm_q  <= 1'b1;
        mode_q <= inj_mode;
      end else if (accept_c) begin
        arm_q <= 1'b0;
      end
      if (cnt_clr) begin
        sbit_cnt  <= '0;
        dbit_cnt  <= '0;
        fault_cnt <= '0;
      end else if (accept_c) begin
        if (sbit0_c) sbit_cnt  <= sat_inc(sbit_cnt);
        if (dbit0_c) dbit_cnt  <= sat_inc(dbit_cnt);
        if (fault_c) fault_cnt <= sat_inc(fault_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OK;
      run_q       <= '0;
      fault_fatal <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      fault_fatal <= (state_d == ST_LOCKED);
    end
  end

  // Persistence FSM: only accepted beats advance it; fatal_clr overrides everything
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (fatal_clr) begin
      state_d = ST_OK;
      run_d   = '0;
    end else if (accept_c) begin
      case (state_q)
        ST_OK: begin
          if (fault_c) begin
            run_d   = RUN_W'(1);
            state_d = (FAULT_THRESH == 1) ? ST_LOCKED : ST_SUSPECT;
          end
        end
        ST_SUSPECT: begin
          if (fault_c) begin
            run_d = run_q + RUN_W'(1);
            if ((run_q + RUN_W'(1)) >= RUN_W'(FAULT_THRESH)) state_d = ST_LOCKED;
          end else begin
            run_d   = '0;
            state_d = ST_OK;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default: begin
          state_d = ST_OK;
          run_d   = '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_fault_detc_pipe.sv
// Directed bench for ecc_fault_detc_pipe; a second CNT_WIDTH=2 instance shares the
// stimulus to exercise counter saturation.

module tb_ecc_fault_detc_pipe;
  localparam int unsigned DW = 131;
  localparam int unsigned PW = 9;

  logic          clk = 1'b0;
  logic          rst, en, bypass, in_vld, out_rdy, fatal_clr, cnt_clr, inj_arm;
  logic [1:0]    inj_mode;
  logic [DW-1:0] data_in;
  logic [PW-1:0] parity_in;

  logic          in_rdy, out_vld, sbit_err, dbit_err, ecc_fault, fault_fatal;
  logic [DW-1:0] data_out;
  logic [15:0]   sbit_cnt, dbit_cnt, fault_cnt;

  logic          s_in_rdy, s_out_vld, s_sbit_err, s_dbit_err, s_ecc_fault, s_fault_fatal;
  logic [DW-1:0] s_data_out;
  logic [1:0]    s_sbit_cnt, s_dbit_cnt, s_fault_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Data bit 3 sits at Hamming position 7 -> check bits 0..2 set, overall parity even
  logic [DW-1:0] d1;

  always #5 clk = ~clk;

  ecc_fault_detc_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(16), .FAULT_THRESH(4)) dut (
    .clk(clk), .rst(rst), .ecc_fault_detc_en(en), .bypass(bypass),
    .in_vld(in_vld), .in_rdy(in_rdy), .data_in(data_in), .parity_in(parity_in),
    .out_vld(out_vld), .out_rdy(out_rdy), .data_out(data_out),
    .sbit_err(sbit_err), .dbit_err(dbit_err), .ecc_fault(ecc_fault),
    .fault_fatal(fault_fatal), .fatal_clr(fatal_clr), .cnt_clr(cnt_clr),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .inj_arm(inj_arm), .inj_mode(inj_mode)
  );

  ecc_fault_detc_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(2), .FAULT_THRESH(4)) dut_small (
    .clk(clk), .rst(rst), .ecc_fault_detc_en(en), .bypass(bypass),
    .in_vld(in_vld), .in_rdy(s_in_rdy), .data_in(data_in), .parity_in(parity_in),
    .out_vld(s_out_vld), .out_rdy(out_rdy), .data_out(s_data_out),
    .sbit_err(s_sbit_err), .dbit_err(s_dbit_err), .ecc_fault(s_ecc_fault),
    .fault_fatal(s_fault_fatal), .fatal_clr(fatal_clr), .cnt_clr(cnt_clr),
    .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt), .fault_cnt(s_fault_cnt),
    .inj_arm(inj_arm), .inj_mode(inj_mode)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [PW-1:0] p);
    data_in   = d;
    parity_in = p;
    in_vld    = 1'b1;
    tick();
    in_vld    = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m);
    inj_mode = m;
    inj_arm  = 1'b1;
    tick();
    inj_arm  = 1'b0;
  endtask

  initial begin
    d1 = '0;
    d1[3] = 1'b1;
    rst = 1'b1; en = 1'b1; bypass = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    fatal_clr = 1'b0; cnt_clr = 1'b0; inj_arm = 1'b0; inj_mode = 2'd0;
    data_in = '0; parity_in = '0;
    tick();
    tick();
    check("rst_out_vld", out_vld, 0);
    check("rst_data_out", data_out, 0);
    check("rst_flags", {sbit_err, dbit_err, ecc_fault, fault_fatal}, 0);
    check("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
    check("rst_in_rdy", in_rdy, 1);
    rst = 1'b0;
    tick();

    // Clean beat
    beat(d1, 9'h007);
    check("t1_out_vld", out_vld, 1);
    check("t1_data", data_out, d1);
    check("t1_flags", {sbit_err, dbit_err, ecc_fault}, 0);
    tick();
    check("t1_out_vld_drop", out_vld, 0);

    // Single-bit injection on both decoders is corrected
    arm(2'd2);
    beat('0, 9'h000);
    check("t2_sbit", sbit_err, 1);
    check("t2_data", data_out, 0);
    check("t2_fault", ecc_fault, 0);
    check("t2_sbit_cnt", sbit_cnt, 1);
    beat('0, 9'h000);
    check("t2_next_clean", sbit_err, 0);
    check("t2_sbit_cnt_hold", sbit_cnt, 1);

    // Double-bit injection
    arm(2'd3);
    beat('0, 9'h000);
    check("t3_dbit", dbit_err, 1);
    check("t3_no_sbit", sbit_err, 0);
    check("t3_fault", ecc_fault, 0);
    check("t3_dbit_cnt", dbit_cnt, 1);

    // Bypass suppresses decoding of a parity-bit error
    bypass = 1'b1;
    beat('0, 9'h001);
    check("byp_sbit", sbit_err, 0);
    check("byp_sbit_cnt", sbit_cnt, 1);
    bypass = 1'b0;

    // Three mismatches then a clean beat: no fatal
    for (int i = 0; i < 3; i++) begin
      arm(2'd1);
      beat(d1, 9'h007);
      check("t4a_fault", ecc_fault, 1);
      check("t4a_raw", data_out, d1);
      check("t4a_sbit0", sbit_err, 0);
    end
    beat(d1, 9'h007);
    check("t4a_clean", ecc_fault, 0);
    check("t4a_fatal", fault_fatal, 0);
    check("t4a_fault_cnt", fault_cnt, 3);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);

    // Four consecutive mismatches latch fatal
    for (int i = 0; i < 4; i++) begin
      arm(2'd1);
      beat(d1, 9'h007);
      check("t4b_fault", ecc_fault, 1);
      check("t4b_fatal", fault_fatal, (i == 3) ? 1 : 0);
    end
    check("t4b_fault_cnt", fault_cnt, 4);
    beat(d1, 9'h007);
    check("t4b_sticky", fault_fatal, 1);
    fatal_clr = 1'b1;
    tick();
    fatal_clr = 1'b0;
    check("t4b_clr", fault_fatal, 0);

    // Backpressure holds the output and blocks counting
    out_rdy = 1'b0;
    beat(d1, 9'h007);
    check("t5_vld", out_vld, 1);
    data_in = '0; parity_in = 9'h001; in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_in_rdy", in_rdy, 0);
      check("t5_stable", data_out, d1);
    end
    check("t5_cnt_hold", sbit_cnt, 0);
    out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    check("t5_release_data", data_out, 0);
    check("t5_release_sbit", sbit_err, 1);
    check("t5_release_cnt", sbit_cnt, 1);

    // Saturation on the narrow counter, clear-wins, reset drops the beat
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) beat('0, 9'h001);
    check("t6_sat_small", s_sbit_cnt, 3);
    check("t6_wide", sbit_cnt, 5);
    cnt_clr = 1'b1;
    beat('0, 9'h001);
    cnt_clr = 1'b0;
    check("t6_clr_wins", sbit_cnt, 0);
    check("t6_clr_wins_small", s_sbit_cnt, 0);
    check("t6_clr_beat_vld", out_vld, 1);
    rst = 1'b1;
    beat('0, 9'h001);
    rst = 1'b0;
    check("t6_rst_vld", out_vld, 0);
    check("t6_rst_cnt", sbit_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
